// File: rtl/threshold_ctrl.sv
// threshold_ctrl: edge threshold for the Sobel magnitude compare, set by switches or by up/down buttons.
// Latency: switch change to o_threshold 3 cycles; raw button edge to o_threshold 2 + DEBOUNCE_CYCLES + 1 cycles.
// Backpressure: none; o_threshold is always valid and o_th_update pulses once for every value change.
// Ports:
//   i_clk, i_rst      system clock, synchronous active-high reset
//   i_switches        raw threshold switches (asynchronous), mapped to the threshold MSBs in switch mode
//   i_mode_sel        raw mode select: 0 = switch mode, 1 = button mode
//   i_btn_up/down     raw step buttons, active-high, with auto-repeat while held
//   i_btn_reset       raw button that reloads TH_RESET in either mode
//   o_threshold       current threshold (registered)
//   o_th_update       one-cycle strobe in the cycle o_threshold shows a new value
module threshold_ctrl #(
   parameter int TH_W            = 8,
   parameter int SW_W            = 4,
   parameter int TH_RESET        = 128,
   parameter int STEP            = 4,
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int REPEAT_CYCLES   = 25000000
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic [SW_W-1:0] i_switches,
   input  logic            i_mode_sel,
   input  logic            i_btn_up,
   input  logic            i_btn_down,
   input  logic            i_btn_reset,
   output logic [TH_W-1:0] o_threshold,
   output logic            o_th_update
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int RC_W = $clog2(REPEAT_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [RC_W-1:0] RC_LAST = RC_W'(REPEAT_CYCLES - 1);
   localparam logic [TH_W:0]   STEP_X  = (TH_W + 1)'(STEP);
   localparam logic [TH_W-1:0] TH_INIT = TH_W'(TH_RESET);

   // button lanes inside the debounce vectors
   localparam int B_UP  = 0;
   localparam int B_DN  = 1;
   localparam int B_RST = 2;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_HOLD_UP = 2'd1;
   localparam logic [1:0] ST_HOLD_DN = 2'd2;

   logic [SW_W-1:0] r_sw_s1, r_sw_s2;
   logic            r_mode_s1, r_mode_s2, r_mode_q;
   logic [2:0]      r_btn_s1, r_btn_s2;
   logic [2:0]      r_btn_stb, r_btn_stb_q;
   logic [DB_W-1:0] r_db_cnt [3];
   logic [TH_W-1:0] r_target_q;
   logic [1:0]      r_state;
   logic [RC_W-1:0] r_rpt_cnt;
   logic [TH_W-1:0] r_threshold;
   logic            r_th_update;

   logic [2:0]      w_press;
   logic [TH_W-1:0] w_target;
   logic [TH_W:0]   w_sum, w_diff;
   logic [TH_W-1:0] w_up_val, w_dn_val;
   logic [TH_W-1:0] w_th_nxt;
   logic [1:0]      w_state_nxt;
   logic [RC_W-1:0] w_rpt_nxt;

   // Synchronisers and per-button debounce: the stable level only follows the
   // synchronised level after it has differed for DEBOUNCE_CYCLES in a row.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sw_s1     <= '0;
         r_sw_s2     <= '0;
         r_mode_s1   <= 1'b0;
         r_mode_s2   <= 1'b0;
         r_btn_s1    <= '0;
         r_btn_s2    <= '0;
         r_btn_stb   <= '0;
         r_btn_stb_q <= '0;
         for (int i = 0; i < 3; i++) r_db_cnt[i] <= '0;
      end else begin
         r_sw_s1     <= i_switches;
         r_sw_s2     <= r_sw_s1;
         r_mode_s1   <= i_mode_sel;
         r_mode_s2   <= r_mode_s1;
         r_btn_s1    <= {i_btn_reset, i_btn_down, i_btn_up};
         r_btn_s2    <= r_btn_s1;
         r_btn_stb_q <= r_btn_stb;
         for (int i = 0; i < 3; i++) begin
            if (r_btn_s2[i] == r_btn_stb[i]) begin
               r_db_cnt[i] <= '0;
            end else if (r_db_cnt[i] == DB_LAST) begin
               r_db_cnt[i]  <= '0;
               r_btn_stb[i] <= r_btn_s2[i];
            end else begin
               r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
            end
         end
      end
   end

   assign w_press  = r_btn_stb & ~r_btn_stb_q;
   assign w_target = TH_W'(r_sw_s2) << (TH_W - SW_W);

   // One extra bit carries overflow (up) or borrow (down) so the step saturates.
   assign w_sum    = {1'b0, r_threshold} + STEP_X;
   assign w_diff   = {1'b0, r_threshold} - STEP_X;
   assign w_up_val = w_sum[TH_W]  ? '1 : w_sum[TH_W-1:0];
   assign w_dn_val = w_diff[TH_W] ? '0 : w_diff[TH_W-1:0];

   always_comb begin
      w_th_nxt    = r_threshold;
      w_state_nxt = r_state;
      w_rpt_nxt   = r_rpt_cnt;
      if (w_press[B_RST]) begin
         w_th_nxt    = TH_INIT;
         w_state_nxt = ST_IDLE;
         w_rpt_nxt   = '0;
      end else if (r_mode_s2 != r_mode_q) begin
         // entering switch mode reloads from the switches; entering button mode keeps the value
         w_state_nxt = ST_IDLE;
         w_rpt_nxt   = '0;
         if (!r_mode_s2) w_th_nxt = w_target;
      end else if (!r_mode_s2) begin
         // only a switch movement reloads, so a btn_reset value survives until then
         w_state_nxt = ST_IDLE;
         w_rpt_nxt   = '0;
         if (w_target != r_target_q) w_th_nxt = w_target;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_press[B_UP] && !w_press[B_DN]) begin
                  w_th_nxt    = w_up_val;
                  w_state_nxt = ST_HOLD_UP;
                  w_rpt_nxt   = '0;
               end else if (w_press[B_DN] && !w_press[B_UP]) begin
                  w_th_nxt    = w_dn_val;
                  w_state_nxt = ST_HOLD_DN;
                  w_rpt_nxt   = '0;
               end
            end
            ST_HOLD_UP: begin
               if (!r_btn_stb[B_UP] || r_btn_stb[B_DN]) begin
                  w_state_nxt = ST_IDLE;
                  w_rpt_nxt   = '0;
               end else if (r_rpt_cnt == RC_LAST) begin
                  w_th_nxt  = w_up_val;
                  w_rpt_nxt = '0;
               end else begin
                  w_rpt_nxt = r_rpt_cnt + RC_W'(1);
               end
            end
            ST_HOLD_DN: begin
               if (!r_btn_stb[B_DN] || r_btn_stb[B_UP]) begin
                  w_state_nxt = ST_IDLE;
                  w_rpt_nxt   = '0;
               end else if (r_rpt_cnt == RC_LAST) begin
                  w_th_nxt  = w_dn_val;
                  w_rpt_nxt = '0;
               end else begin
                  w_rpt_nxt = r_rpt_cnt + RC_W'(1);
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_rpt_nxt   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_threshold <= TH_INIT;
         r_th_update <= 1'b0;
         r_state     <= ST_IDLE;
         r_rpt_cnt   <= '0;
         r_mode_q    <= 1'b0;
         r_target_q  <= '0;
      end else begin
         r_threshold <= w_th_nxt;
         // strobe only on a real value change, so saturated or equal reloads stay silent
         r_th_update <= (w_th_nxt != r_threshold);
         r_state     <= w_state_nxt;
         r_rpt_cnt   <= w_rpt_nxt;
         r_mode_q    <= r_mode_s2;
         r_target_q  <= w_target;
      end
   end

   assign o_threshold = r_threshold;
   assign o_th_update = r_th_update;

endmodule
